// File: rtl/reaction_pkg.sv
// reaction_pkg: shared state encoding and widths for the reaction timer.
package reaction_pkg;
  localparam int RT_W = 14;
  localparam logic [RT_W-1:0] RT_BEST_INIT = 14'h3FFF;
  typedef enum logic [2:0] {IDLE, ARMED, TIMING, DONE, FAULT} rt_state_t;
endpackage

// File: rtl/key_sync.sv
// key_sync: synchronizes the raw active-low key and emits one registered pulse per falling edge.
module key_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);
  logic [STAGES-1:0] sync_q;
  logic prev_q, press_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '1;
      prev_q  <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[STAGES-2:0], key_n};
      prev_q  <= sync_q[STAGES-1];
      press_q <= prev_q & ~sync_q[STAGES-1];
    end
  end
  assign press = press_q;
endmodule

// File: rtl/reaction_timer.sv
// reaction_timer: arm/go/press reaction-time measurement with false-start and timeout flags.
// Defining REACTION_BEST_EN adds the best_ms output tracking the fastest valid trial.
module reaction_timer
  import reaction_pkg::*;
#(
  parameter int MAX_MS      = 9999,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLOCK_50,
  input  logic            rst_n,
  input  logic            tick_ms,
  input  logic            arm,
  input  logic            go,
  input  logic            key_n,
  output logic [RT_W-1:0] rt_ms,
  output logic            result_valid,
  output logic            false_start,
  output logic            timeout,
  output logic            busy
`ifdef REACTION_BEST_EN
  ,
  output logic [RT_W-1:0] best_ms
`endif
);
  localparam logic [RT_W-1:0] MAX_CNT = RT_W'(MAX_MS);
  rt_state_t state_q, state_d;
  logic [RT_W-1:0] cnt_q, cnt_d, cnt_inc, rt_q, rt_d;
  logic valid_q, valid_d, fs_q, fs_d, to_q, to_d, pend_q, pend_d, press;

  key_sync #(.STAGES(SYNC_STAGES)) u_key (
    .clk   (CLOCK_50),
    .rst_n (rst_n),
    .key_n (key_n),
    .press (press)
  );

  // pend_q remembers a press that coincided with go; it resolves as a 0 ms result
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rt_d    = rt_q;
    valid_d = valid_q;
    fs_d    = fs_q;
    to_d    = to_q;
    pend_d  = pend_q;
    cnt_inc = tick_ms ? cnt_q + 1'b1 : cnt_q;
    if (arm) begin
      state_d = ARMED;
      cnt_d   = '0;
      rt_d    = '0;
      valid_d = 1'b0;
      fs_d    = 1'b0;
      to_d    = 1'b0;
      pend_d  = 1'b0;
    end else begin
      case (state_q)
        ARMED: begin
          if (go) begin
            state_d = TIMING;
            cnt_d   = '0;
            pend_d  = press;
          end else if (press) begin
            state_d = FAULT;
            fs_d    = 1'b1;
          end
        end
        TIMING: begin
          if (pend_q || press) begin
            state_d = DONE;
            rt_d    = pend_q ? cnt_q : cnt_inc;
            valid_d = 1'b1;
            pend_d  = 1'b0;
          end else if (cnt_inc == MAX_CNT) begin
            state_d = FAULT;
            cnt_d   = cnt_inc;
            rt_d    = MAX_CNT;
            to_d    = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rt_q    <= '0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      to_q    <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rt_q    <= rt_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      to_q    <= to_d;
      pend_q  <= pend_d;
    end
  end

  assign rt_ms        = rt_q;
  assign result_valid = valid_q;
  assign false_start  = fs_q;
  assign timeout      = to_q;
  assign busy         = state_q == ARMED || state_q == TIMING;

`ifdef REACTION_BEST_EN
  logic done_q;
  logic [RT_W-1:0] best_q;
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      best_q <= RT_BEST_INIT;
    end else begin
      done_q <= state_q == TIMING && state_d == DONE;
      if (done_q && rt_q < best_q) best_q <= rt_q;
    end
  end
  assign best_ms = best_q;
`endif
endmodule

// File: tb/tb_reaction_timer.sv
// tb_reaction_timer: scoreboard-driven bench for reaction_timer (honours REACTION_BEST_EN).
module tb_reaction_timer;
  logic CLOCK_50 = 1'b0;
  logic rst_n = 1'b0, tick_ms = 1'b0, arm = 1'b0, go = 1'b0, key_n = 1'b1;
  logic [13:0] rt_ms;
  logic result_valid, false_start, timeout, busy;
`ifdef REACTION_BEST_EN
  logic [13:0] best_ms;
`endif

  typedef struct packed {
    logic [13:0] rt;
    logic v;
    logic fs;
    logic to;
  } exp_t;
  exp_t sb[$];
  int errors = 0, checks = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  reaction_timer dut (
    .CLOCK_50     (CLOCK_50),
    .rst_n        (rst_n),
    .tick_ms      (tick_ms),
    .arm          (arm),
    .go           (go),
    .key_n        (key_n),
    .rt_ms        (rt_ms),
    .result_valid (result_valid),
    .false_start  (false_start),
    .timeout      (timeout),
    .busy         (busy)
`ifdef REACTION_BEST_EN
    ,
    .best_ms      (best_ms)
`endif
  );

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    @(negedge CLOCK_50);
    arm = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge CLOCK_50);
    go = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_ms = 1'b1;
      @(negedge CLOCK_50);
      tick_ms = 1'b0;
      @(negedge CLOCK_50);
    end
  endtask

  task automatic press_key(input logic [13:0] rt, input logic v, input logic fs, input logic to);
    sb.push_back('{rt: rt, v: v, fs: fs, to: to});
    key_n = 1'b0;
  endtask

  task automatic release_key();
    repeat (3) @(negedge CLOCK_50);
    key_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic finish_trial(output exp_t e, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLOCK_50);
      if (result_valid || false_start || timeout) begin
        ok = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({rt_ms, result_valid, false_start, timeout, busy} !== 18'd0) begin
      errors++;
      $display("FAIL reset_outputs: got rt=%0d v=%b fs=%b to=%b busy=%b want all 0",
               rt_ms, result_valid, false_start, timeout, busy);
    end
`ifdef REACTION_BEST_EN
    checks++;
    if (best_ms !== 14'h3FFF) begin
      errors++;
      $display("FAIL reset_best: got %h want 3fff", best_ms);
    end
`endif
  endtask

  task automatic test_basic();
    exp_t e;
    bit ok;
    pulse_arm();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: got %b want 1", busy);
    end
    pulse_go();
    ticks(250);
    press_key(14'd250, 1'b1, 1'b0, 1'b0);
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL basic_250: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    release_key();
  endtask

  task automatic test_false_start();
    exp_t e;
    bit ok;
    pulse_arm();
    press_key(14'd0, 1'b0, 1'b1, 1'b0);
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL false_start: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    pulse_go();
    ticks(3);
    checks++;
    if ({rt_ms, result_valid, false_start, timeout, busy} !== {14'd0, 4'b0100}) begin
      errors++;
      $display("FAIL false_start_go_ignored: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=0 v=0 fs=1 to=0 busy=0",
               rt_ms, result_valid, false_start, timeout, busy);
    end
    release_key();
  endtask

  task automatic test_timeout();
    exp_t e;
    bit ok;
    pulse_arm();
    pulse_go();
    ticks(9998);
    checks++;
    if ({timeout, busy} !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early: got to=%b busy=%b want to=0 busy=1", timeout, busy);
    end
    sb.push_back('{rt: 14'd9999, v: 1'b0, fs: 1'b0, to: 1'b1});
    ticks(1);
    checks++;
    if (timeout !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge: got to=%b want 1 right after tick 9999", timeout);
    end
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL timeout: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    key_n = 1'b0;
    repeat (8) @(negedge CLOCK_50);
    checks++;
    if ({rt_ms, result_valid, false_start, timeout, busy} !== {14'd9999, 4'b0010}) begin
      errors++;
      $display("FAIL timeout_press_ignored: got rt=%0d v=%b fs=%b to=%b want rt=9999 v=0 fs=0 to=1",
               rt_ms, result_valid, false_start, timeout);
    end
    release_key();
  endtask

  task automatic test_simultaneous();
    exp_t e;
    bit ok;
    pulse_arm();
    press_key(14'd0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    go = 1'b1;
    @(negedge CLOCK_50);
    go = 1'b0;
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL press_with_go: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    release_key();
    pulse_arm();
    pulse_go();
    ticks(16);
    press_key(14'd17, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge CLOCK_50);
    tick_ms = 1'b1;
    @(negedge CLOCK_50);
    tick_ms = 1'b0;
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL press_with_tick: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    release_key();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    bit ok;
    pulse_arm();
    pulse_go();
    ticks(5);
    pulse_arm();
    checks++;
    if ({rt_ms, result_valid, busy} !== {14'd0, 2'b01}) begin
      errors++;
      $display("FAIL rearm: got rt=%0d v=%b busy=%b want rt=0 v=0 busy=1", rt_ms, result_valid, busy);
    end
    pulse_go();
    ticks(12);
    press_key(14'd12, 1'b1, 1'b0, 1'b0);
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL rearm_trial: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    release_key();
  endtask

  task automatic test_mid_reset();
    exp_t e;
    bit ok;
    pulse_arm();
    pulse_go();
    ticks(100);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rt_ms, result_valid, false_start, timeout, busy} !== 18'd0) begin
      errors++;
      $display("FAIL mid_reset: got rt=%0d v=%b fs=%b to=%b busy=%b want all 0",
               rt_ms, result_valid, false_start, timeout, busy);
    end
    @(negedge CLOCK_50);
    rst_n = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: got busy=%b want 0", busy);
    end
    pulse_arm();
    pulse_go();
    ticks(40);
    press_key(14'd40, 1'b1, 1'b0, 1'b0);
    finish_trial(e, ok);
    checks++;
    if (!ok || {rt_ms, result_valid, false_start, timeout, busy} !== {e.rt, e.v, e.fs, e.to, 1'b0}) begin
      errors++;
      $display("FAIL after_reset_40: got rt=%0d v=%b fs=%b to=%b busy=%b want rt=%0d v=%b fs=%b to=%b busy=0",
               rt_ms, result_valid, false_start, timeout, busy, e.rt, e.v, e.fs, e.to);
    end
    release_key();
  endtask

`ifdef REACTION_BEST_EN
  task automatic test_best();
    int trial_ms[4] = '{300, 180, 0, 220};
    bit trial_fs[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [13:0] model = 14'h3FFF;
    exp_t e;
    bit ok;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      pulse_arm();
      if (trial_fs[i]) begin
        press_key(14'd0, 1'b0, 1'b1, 1'b0);
      end else begin
        pulse_go();
        ticks(trial_ms[i]);
        press_key(14'(trial_ms[i]), 1'b1, 1'b0, 1'b0);
      end
      finish_trial(e, ok);
      checks++;
      if (!ok || {rt_ms, result_valid, false_start, timeout} !== {e.rt, e.v, e.fs, e.to}) begin
        errors++;
        $display("FAIL best_trial%0d: got rt=%0d v=%b fs=%b to=%b want rt=%0d v=%b fs=%b to=%b",
                 i, rt_ms, result_valid, false_start, timeout, e.rt, e.v, e.fs, e.to);
      end
      checks++;
      if (best_ms !== model) begin
        errors++;
        $display("FAIL best_lag%0d: got %0d want %0d (not yet updated)", i, best_ms, model);
      end
      if (!trial_fs[i] && 14'(trial_ms[i]) < model) model = 14'(trial_ms[i]);
      @(negedge CLOCK_50);
      checks++;
      if (best_ms !== model) begin
        errors++;
        $display("FAIL best%0d: got %0d want %0d", i, best_ms, model);
      end
      release_key();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_false_start();
    test_timeout();
    test_simultaneous();
    test_back_to_back();
    test_mid_reset();
`ifdef REACTION_BEST_EN
    test_best();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reaction_timer.md
# reaction_timer

Response-side companion to the starting-line/random-delay logic in the reaction-timer game. The block arms on a start pulse and waits for the "lights out" event. It then counts millisecond ticks until the player presses the key, and holds the result for the BCD/7-segment display path. A key press before lights out is flagged as a false start; no press within the window is flagged as a timeout.

## Interface
Parameters:
- `MAX_MS`, 9999: timeout limit in ms; must be ≤ 16383 (fits `rt_ms`).
- `SYNC_STAGES`, 2: synchronizer depth for the key input; must be ≥ 2.

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz.
- `rst_n` in 1: asynchronous active-low reset.
- `tick_ms` in 1: one-cycle pulse every 1 ms, synchronous to `CLOCK_50`.
- `arm` in 1: one-cycle pulse that starts a new trial.
- `go` in 1: one-cycle "lights out" pulse (delay expiry).
- `key_n` in 1: raw asynchronous push button, active-low.
- `rt_ms` out 14: reaction time in ms; valid while `result_valid`=1.
- `result_valid` out 1: level; a trial completed with a valid press.
- `false_start` out 1: level; press detected while ARMED.
- `timeout` out 1: level; no press within `MAX_MS`.
- `busy` out 1: high in ARMED or TIMING.

## Operation
- Key path: `key_n` passes through `SYNC_STAGES` flops and a falling-edge detector, producing a one-cycle `press` pulse. Holding the key produces exactly one pulse.
- FSM states and transitions:
  - IDLE: `arm` → ARMED, clearing the counter and all flags.
  - ARMED: `press` → FAULT with `false_start`=1. Otherwise `go` → TIMING with the counter at 0.
  - TIMING: the counter increments on each `tick_ms`. `press` → DONE with `rt_ms`=counter and `result_valid`=1. A counter value of `MAX_MS` → FAULT with `timeout`=1 and `rt_ms`=`MAX_MS`.
  - DONE and FAULT: outputs hold. `arm` → ARMED and clears `rt_ms`, `result_valid`, `false_start` and `timeout`.
- Simultaneous events:
  - `press` and `go` in the same cycle in ARMED: `go` wins. The block enters TIMING, and the press is captured in the next cycle as a valid result with `rt_ms`=0.
  - `press` and `tick_ms` in the same cycle in TIMING: the tick is counted first, so `rt_ms` = prior count + 1.
  - `arm` in ARMED or TIMING restarts the trial: flags and counter clear, and the state goes to ARMED.
  - `go` is ignored outside ARMED. `press` is ignored in IDLE, DONE and FAULT.
- Counter arithmetic: 14-bit unsigned. The counter never exceeds `MAX_MS` and never wraps.

## Timing
- Reset values:
  - `rt_ms`=0, `result_valid`=0, `false_start`=0, `timeout`=0, `busy`=0.
  - State = IDLE; synchronizer flops = 1 (key released).
- Key latency: a falling edge on `key_n` produces `press` in cycle `SYNC_STAGES`+1. All outputs update one cycle after `press`.
- `go` to TIMING: 1 cycle. `arm` to ARMED and `busy`=1: 1 cycle.
- Timeout: `timeout` asserts 1 cycle after the tick that brings the counter to `MAX_MS`.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset asserted mid-trial returns the block to IDLE immediately, with all outputs at their reset values.

## Configuration
- `REACTION_BEST_EN`: when defined, adds output `best_ms[13:0]`.
  - `best_ms` resets to 14'h3FFF.
  - On entry to DONE, `best_ms` updates to min(`best_ms`, captured time), 1 cycle after the `rt_ms` update.
  - False starts and timeouts never update `best_ms`.
- When undefined, the port and its register are absent; all other behaviour is identical.

## Structure
- Package `reaction_pkg`:
  - State enum `rt_state_t` {IDLE, ARMED, TIMING, DONE, FAULT}.
  - `RT_W`=14.
  - `RT_BEST_INIT`=14'h3FFF.
- Sub-module `key_sync`: parameterised synchronizer plus falling-edge detector. Ports: clock, reset, `key_n`, `press`.
- Top: FSM, millisecond counter, result and flag registers.

## Test plan
- Reset, `arm`, `go`, 250 `tick_ms` pulses, then `key_n` falls → `rt_ms`=250, `result_valid`=1, `busy`=0.
- `arm`, `key_n` falls before `go` → `false_start`=1, `result_valid`=0. A later `go` is ignored and the state stays in FAULT.
- `arm`, `go`, no press for 9999 ticks → `timeout`=1, `rt_ms`=9999. A press afterwards changes nothing.
- `press` in the same cycle as `go` → `rt_ms`=0 and `result_valid`=1. `press` in the same cycle as the 17th tick → `rt_ms`=17.
- `rst_n` pulled low at tick 100 in TIMING → all outputs 0 and IDLE. Next trial measures 40 → `rt_ms`=40.
- `REACTION_BEST_EN` defined: trials of 300, 180, then a false start, then 220 → `best_ms` reads 300, 180, 180, 180.
